cim_cmd_issuer: RTL and testbench

CIM_CMD_ISSUER -- requirements
Module: cim_cmd_issuer

---
 rtl/cim_cmd_issuer.sv | 109 ++++++++++
 tb/tb_cim_cmd_issuer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_cmd_issuer.sv
// Command issuer for the CIM macro: buffers host instruction words in a small FIFO
// and issues them in order as compute or one-cycle load/store commands.
module cim_cmd_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned Col_num = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [31:0]        cmd_data,
  output logic               Compute_valid,
  input  logic               Compute_ready,
  output logic [24:0]        Compute_command,
  output logic               ExLdSt_valid,
  output logic [6:0]         ExLdSt_command,
  output logic [Col_num-1:0] ExLdSt_wr_data,
  input  logic [Col_num-1:0] ExLdSt_rd_data,
  output logic [Col_num-1:0] rd_data,
  output logic               rd_valid,
  output logic               busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, CMP, LDST} state_t;

  state_t             state, state_nxt;
  logic [25:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wptr, rptr;
  logic [CNT_W-1:0]   count;
  logic [25:0]        head;
  logic               push, pop, leave, head_ls;
  logic               unused_bits;

  // Only the type bit and the low 25 bits carry meaning; the rest is dropped at entry.
  assign unused_bits = ^cmd_data[30:25];

  assign cmd_ready = (count != CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rptr];
  assign head_ls   = head[25];
  assign busy      = (count != '0) || (state != IDLE);

  always_comb begin
    leave = 1'b1;
    case (state)
      CMP:     leave = Compute_ready;
      default: leave = 1'b1;
    endcase
    pop       = leave && (count != '0);
    state_nxt = state;
    if (leave) begin
      if (!pop)         state_nxt = IDLE;
      else if (head_ls) state_nxt = LDST;
      else              state_nxt = CMP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cmd_data[31], cmd_data[24:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Issue registers are reloaded only on the edge that leaves the current state,
  // which keeps a stalled compute command stable and zeroes outputs when going idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      Compute_valid   <= 1'b0;
      Compute_command <= '0;
      ExLdSt_valid    <= 1'b0;
      ExLdSt_command  <= '0;
      ExLdSt_wr_data  <= '0;
      rd_data         <= '0;
      rd_valid        <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == LDST && !ExLdSt_command[6]) begin
        rd_data  <= ExLdSt_rd_data;
        rd_valid <= 1'b1;
      end
      if (leave) begin
        Compute_valid   <= pop && !head_ls;
        Compute_command <= (pop && !head_ls) ? head[24:0] : '0;
        ExLdSt_valid    <= pop && head_ls;
        ExLdSt_command  <= (pop && head_ls) ? head[6:0] : '0;
        ExLdSt_wr_data  <= (pop && head_ls) ? Col_num'(head[22:7]) : '0;
      end
    end
  end

endmodule

// File: tb/tb_cim_cmd_issuer.sv
// Scoreboard bench for cim_cmd_issuer: directed scenarios plus randomized traffic,
// with a negedge monitor comparing every issued command against an in-order queue.
module tb_cim_cmd_issuer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned COLS  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid, cmd_ready, Compute_valid, Compute_ready;
  logic [31:0]     cmd_data;
  logic [24:0]     Compute_command;
  logic            ExLdSt_valid, rd_valid, busy;
  logic [6:0]      ExLdSt_command;
  logic [COLS-1:0] ExLdSt_wr_data, ld_data, rd_data;

  typedef struct packed {
    logic        is_ls;
    logic [24:0] cc;
    logic [6:0]  lc;
    logic [15:0] wd;
  } item_t;

  item_t       exp_q[$];
  item_t       mon_h;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          ld_fix = 1'b0;
  bit          exp_issue = 1'b0;
  bit          rd_pend = 1'b0;
  logic [15:0] rd_val = '0;

  cim_cmd_issuer #(.DEPTH(DEPTH), .Col_num(COLS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .Compute_valid(Compute_valid), .Compute_ready(Compute_ready),
    .Compute_command(Compute_command),
    .ExLdSt_valid(ExLdSt_valid), .ExLdSt_command(ExLdSt_command),
    .ExLdSt_wr_data(ExLdSt_wr_data), .ExLdSt_rd_data(ld_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    ld_data = ld_fix ? 16'h1234 : 16'($urandom);
  end

  function automatic item_t decode(input logic [31:0] w);
    item_t it;
    it.is_ls = w[31];
    it.cc    = w[24:0];
    it.lc    = w[6:0];
    it.wd    = w[22:7];
    return it;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: inputs are stable at negedge, so the upcoming edge's push/reset is known here.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", {31'b0, busy}, {31'b0, exp_q.size() != 0});
      chk("issue_timing", {31'b0, Compute_valid || ExLdSt_valid}, {31'b0, exp_issue});
      chk("one_valid", {31'b0, Compute_valid && ExLdSt_valid}, 0);
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, rd_pend});
      chk("rd_data", {16'b0, rd_data}, {16'b0, rd_val});
      rd_pend = 1'b0;
      if (Compute_valid || ExLdSt_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_issue", 1, 0);
        end else begin
          mon_h = exp_q[0];
          chk("kind", {31'b0, ExLdSt_valid}, {31'b0, mon_h.is_ls});
          if (Compute_valid) begin
            chk("cmp_cmd", {7'b0, Compute_command}, {7'b0, mon_h.cc});
            if (Compute_ready) void'(exp_q.pop_front());
          end else begin
            chk("ls_cmd", {25'b0, ExLdSt_command}, {25'b0, mon_h.lc});
            chk("ls_wdata", {16'b0, ExLdSt_wr_data}, {16'b0, mon_h.wd});
            void'(exp_q.pop_front());
            if (!mon_h.lc[6]) begin
              rd_pend = 1'b1;
              rd_val  = ld_data;
            end
          end
        end
      end
      if (!Compute_valid) chk("cmp_idle_zero", {7'b0, Compute_command}, 0);
      if (!ExLdSt_valid) chk("ls_idle_zero", {9'b0, ExLdSt_command, ExLdSt_wr_data}, 0);
      exp_issue = (Compute_valid && !Compute_ready) || (exp_q.size() != 0);
      if (rst) begin
        exp_q.delete();
        rd_pend   = 1'b0;
        rd_val    = '0;
        exp_issue = 1'b0;
      end else if (cmd_valid && cmd_ready) begin
        exp_q.push_back(decode(cmd_data));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data  = w;
    while (!cmd_ready && n < 50) begin
      step(1);
      n++;
    end
    if (n >= 50) chk("push_timeout", 1, 0);
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      step(1);
      n++;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", {31'b0, busy}, 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_cvalid"}, {31'b0, Compute_valid}, 0);
    chk({tag, "_lsvalid"}, {31'b0, ExLdSt_valid}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_ready"}, {31'b0, cmd_ready}, 1);
    chk({tag, "_rdvalid"}, {31'b0, rd_valid}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    cmd_valid     = 1'b0;
    cmd_data      = '0;
    Compute_ready = 1'b0;
    step(2);
    rst    = 1'b0;
    mon_en = 1'b1;
    check_quiet("reset");
    chk("reset_rd_data", {16'b0, rd_data}, 0);

    // Single store
    Compute_ready = 1'b1;
    push(32'h8000_0000 | (32'hBEEF << 7) | 32'h45);
    step(4);

    // Load capture with fixed read data
    ld_fix = 1'b1;
    push(32'h8000_0003);
    step(4);
    ld_fix = 1'b0;
    step(2);
    chk("load_hold", {16'b0, rd_data}, 32'h1234);

    // MUL stall followed by an immediately issued store
    Compute_ready = 1'b0;
    push(32'h000F_0A05);
    push(32'h8000_0000 | (32'h5555 << 7) | 32'h11);
    for (int c = 1; c <= 8; c++) begin
      chk("stall_valid", {31'b0, Compute_valid}, 1);
      chk("stall_cmd", {7'b0, Compute_command}, 32'h000F_0A05);
      if (c == 8) Compute_ready = 1'b1;
      step(1);
    end
    chk("stall_no_bubble", {31'b0, ExLdSt_valid}, 1);
    drain();

    // Full FIFO: first word held in CMP, DEPTH words fill the FIFO, one refused
    Compute_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i % 2 == 1) push(32'h8000_0000 | (32'(i) << 7) | 32'h40 | 32'(i));
      else            push(32'h0010_0000 | 32'(i));
    end
    chk("full_ready", {31'b0, cmd_ready}, 0);
    cmd_valid = 1'b1;
    cmd_data  = 32'h0077_7777;
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("full_refuse", {31'b0, cmd_ready}, 0);
    end
    cmd_valid     = 1'b0;
    Compute_ready = 1'b1;
    drain();

    // Mixed back-to-back: load, compute, store
    push(32'h8000_0005);
    push(32'h0001_2345);
    push(32'h8000_0000 | (32'hA5A5 << 7) | 32'h4A);
    drain();

    // Reset while in CMP with two words queued
    Compute_ready = 1'b0;
    push(32'h0000_0ABC);
    push(32'h8000_0007);
    push(32'h0000_0DEF);
    chk("pre_reset_cmp", {31'b0, Compute_valid}, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_quiet("mid_reset");
    Compute_ready = 1'b1;
    step(6);
    check_quiet("post_reset");

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      w             = $urandom;
      cmd_valid     = ($urandom_range(0, 1) == 1);
      cmd_data      = w;
      Compute_ready = ($urandom_range(0, 9) < 6);
      rst           = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst           = 1'b0;
    cmd_valid     = 1'b0;
    Compute_ready = 1'b1;
    drain();
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
